// File: rtl/axi_lite_intr_pkg.sv
// axi_lite_intr_pkg: register map, response code, FSM states and byte-strobe merge
// shared by the AXI4-Lite interrupt controller.
package axi_lite_intr_pkg;
    localparam logic [4:0] ADDR_GIE = 5'h00;
    localparam logic [4:0] ADDR_IER = 5'h04;
    localparam logic [4:0] ADDR_ISR = 5'h08;
    localparam logic [4:0] ADDR_IAR = 5'h0C;
    localparam logic [4:0] ADDR_IPR = 5'h10;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return res;
    endfunction
endpackage

// File: rtl/axi_lite_intr_ctrl_intr_detect.sv
// intr_detect: one interrupt source -- edge or level detection feeding a sticky ISR bit
// that software clears; a new set in the same cycle as a clear keeps the bit.
module intr_detect
    import axi_lite_intr_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic intr_i,
    input  logic clr_i,
    output logic isr_o
);
    logic in_q, prev_q, isr_q, isr_d, set;
    // edge sources compare the registered input against its previous sample
    assign set   = EDGE ? (in_q & ~prev_q) : intr_i;
    assign isr_d = set | (isr_q & ~clr_i);
    assign isr_o = isr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_q   <= 1'b0;
            prev_q <= 1'b0;
            isr_q  <= 1'b0;
        end else begin
            in_q   <= intr_i;
            prev_q <= in_q;
            isr_q  <= isr_d;
        end
    end
endmodule

// File: rtl/axi_lite_intr_ctrl.sv
// axi_lite_intr_ctrl: AXI4-Lite slave with GIE/IER/ISR/IAR/IPR registers that latches
// up to 32 interrupt sources and drives one registered irq line.
module axi_lite_intr_ctrl
    import axi_lite_intr_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter int          C_NUM_OF_INTR      = 1,
    parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFFFFFF,
    parameter int          C_IRQ_ACTIVE_STATE = 1
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_NUM_OF_INTR-1:0]        intr_in,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);
    localparam int   NI     = C_NUM_OF_INTR;
    localparam logic IRQ_ON = (C_IRQ_ACTIVE_STATE != 0);
    wstate_e w_state_q, w_state_d;
    rstate_e r_state_q, r_state_d;
    logic gie_q, gie_d, irq_q, irq_d, wr_hs, rd_hs, unused;
    logic [NI-1:0] ier_q, ier_d, isr, ack;
    logic [31:0] ier_w, isr_w, ipr_w, ier_new, rdata_q, rdata_d;
    logic [4:0] waddr, raddr;
    assign waddr = {S_AXI_AWADDR[4:2], 2'b00};
    assign raddr = {S_AXI_ARADDR[4:2], 2'b00};
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, ier_new};
    assign S_AXI_BRESP = RESP_OKAY;
    assign S_AXI_RRESP = RESP_OKAY;
    assign S_AXI_RDATA = rdata_q;
    assign irq         = irq_q;
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end
    always_comb begin
        w_state_d = (w_state_q == W_IDLE) ? ((S_AXI_AWVALID && S_AXI_WVALID) ? W_RESP : W_IDLE)
                                          : (S_AXI_BREADY ? W_IDLE : W_RESP);
        r_state_d = (r_state_q == R_IDLE) ? (S_AXI_ARVALID ? R_DATA : R_IDLE)
                                          : (S_AXI_RREADY ? R_IDLE : R_DATA);
    end
    // READY is gated by reset so nothing handshakes while ARESETN is low
    always_comb begin
        wr_hs         = ARESETN && w_state_q == W_IDLE && S_AXI_AWVALID && S_AXI_WVALID;
        rd_hs         = ARESETN && r_state_q == R_IDLE && S_AXI_ARVALID;
        S_AXI_AWREADY = wr_hs;
        S_AXI_WREADY  = wr_hs;
        S_AXI_BVALID  = w_state_q == W_RESP;
        S_AXI_ARREADY = rd_hs;
        S_AXI_RVALID  = r_state_q == R_DATA;
    end
    always_comb begin
        ier_w          = '0;
        ier_w[NI-1:0]  = ier_q;
        isr_w          = '0;
        isr_w[NI-1:0]  = isr;
        ipr_w          = isr_w & ier_w;
        ier_new        = apply_strb(ier_w, S_AXI_WDATA, S_AXI_WSTRB);
        gie_d          = (wr_hs && waddr == ADDR_GIE && S_AXI_WSTRB[0]) ? S_AXI_WDATA[0] : gie_q;
        ier_d          = (wr_hs && waddr == ADDR_IER) ? ier_new[NI-1:0] : ier_q;
        ack            = (wr_hs && waddr == ADDR_IAR) ? S_AXI_WDATA[NI-1:0] : '0;
        irq_d          = (gie_q && |ipr_w) ? IRQ_ON : ~IRQ_ON;
        rdata_d        = raddr == ADDR_GIE ? {31'b0, gie_q} :
                         raddr == ADDR_IER ? ier_w :
                         raddr == ADDR_ISR ? isr_w :
                         raddr == ADDR_IPR ? ipr_w : '0;
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            gie_q   <= 1'b0;
            ier_q   <= '0;
            irq_q   <= ~IRQ_ON;
            rdata_q <= '0;
        end else begin
            gie_q   <= gie_d;
            ier_q   <= ier_d;
            irq_q   <= irq_d;
            rdata_q <= rd_hs ? rdata_d : rdata_q;
        end
    end
    for (genvar i = 0; i < NI; i++) begin : g_det
        intr_detect #(.EDGE(C_INTR_SENSITIVITY[i])) u_det (
            .clk_i (ACLK),
            .rst_ni(ARESETN),
            .intr_i(intr_in[i]),
            .clr_i (ack[i]),
            .isr_o (isr[i])
        );
    end
endmodule
